// File: rtl/priority_scanner_pkg.sv
// Shared definitions for the priority scanner.
//   state_t  : scanner FSM state (IDLE waits for a load, SCAN presents indices)
//   DIR_HIGH : scan order "highest set bit first"
//   DIR_LOW  : scan order "lowest set bit first"
package priority_scanner_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam logic DIR_HIGH = 1'b0;
    localparam logic DIR_LOW  = 1'b1;

endpackage : priority_scanner_pkg

// File: rtl/priority_scanner_find.sv
// pri_find: purely combinational priority finder.
//   vec   : input vector to search
//   dir   : DIR_HIGH selects the highest set bit, DIR_LOW the lowest
//   idx   : index of the selected bit (0 when vec is all zero)
//   found : vec has at least one set bit
module pri_find
    import priority_scanner_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0]         vec,
    input  logic                     dir,
    output logic [$clog2(WIDTH)-1:0] idx,
    output logic                     found
);

    localparam int IDXW = $clog2(WIDTH);

    logic [IDXW-1:0] hi_idx_s;
    logic [IDXW-1:0] lo_idx_s;

    // Two linear scans in opposite directions: the last hit of each wins,
    // which yields the highest and lowest set bit respectively.
    always_comb begin
        hi_idx_s = '0;
        lo_idx_s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            hi_idx_s = vec[i]           ? IDXW'(i)           : hi_idx_s;
            lo_idx_s = vec[WIDTH-1-i]   ? IDXW'(WIDTH-1-i)   : lo_idx_s;
        end
        idx   = (dir == DIR_HIGH) ? hi_idx_s : lo_idx_s;
        found = |vec;
    end

endmodule : pri_find

// File: rtl/priority_scanner.sv
// priority_scanner: captures a request vector and emits the indices of its set
// bits one per accepted transfer, highest-first or lowest-first.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_vec, load, mode    : request vector, capture strobe, scan order (idle only)
//   flush                 : abort the scan and drop pending bits
//   out_idx, out_valid    : current index and its valid flag
//   out_ready             : consumer handshake
//   out_last              : current index is the last pending bit
//   none                  : one-cycle pulse after a load of an all-zero vector
//   busy                  : scan in progress
//   remaining             : number of pending bits
module priority_scanner
    import priority_scanner_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int IDXW  = $clog2(WIDTH),
    parameter int CNTW  = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_vec,
    input  logic             load,
    input  logic             mode,
    input  logic             flush,
    output logic [IDXW-1:0]  out_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             none,
    output logic             busy,
    output logic [CNTW-1:0]  remaining
);

    state_t           state_r;
    state_t           state_next_s;
    logic [WIDTH-1:0] pending_r;
    logic             dir_r;
    logic [CNTW-1:0]  remaining_r;
    logic             none_r;

    logic [IDXW-1:0]  find_idx_s;
    logic             find_found_s;
    logic [CNTW-1:0]  load_pop_s;
    logic             scan_s;
    logic             load_ok_s;
    logic             xfer_s;
    logic             last_s;
    logic [WIDTH-1:0] clear_mask_s;

    pri_find #(
        .WIDTH (WIDTH)
    ) u_find (
        .vec   (pending_r),
        .dir   (dir_r),
        .idx   (find_idx_s),
        .found (find_found_s)
    );

    // Handshake and control decodes; outputs depend on registers only.
    always_comb begin
        scan_s       = (state_r == SCAN);
        load_ok_s    = load && (state_r == IDLE) && !flush;
        xfer_s       = scan_s && out_ready;
        last_s       = scan_s && (remaining_r == CNTW'(1));
        clear_mask_s = {{(WIDTH-1){1'b0}}, 1'b1} << find_idx_s;
    end

    // Popcount of the incoming vector, seeds the remaining counter on load.
    always_comb begin
        load_pop_s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            load_pop_s = load_pop_s + CNTW'(in_vec[i]);
        end
    end

    // Next-state logic; flush overrides every other transition.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (load_ok_s && (in_vec != '0)) begin
                    state_next_s = SCAN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SCAN: begin
                if (xfer_s && last_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = SCAN;
                end
            end
            default: state_next_s = IDLE;
        endcase
        if (flush) begin
            state_next_s = IDLE;
        end else begin
            state_next_s = state_next_s;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Pending bits, scan direction, remaining count and the empty-load pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_r   <= '0;
            dir_r       <= DIR_HIGH;
            remaining_r <= '0;
            none_r      <= 1'b0;
        end else if (flush) begin
            pending_r   <= '0;
            remaining_r <= '0;
            none_r      <= 1'b0;
        end else if (load_ok_s) begin
            pending_r   <= in_vec;
            dir_r       <= mode;
            remaining_r <= load_pop_s;
            none_r      <= (in_vec == '0);
        end else if (xfer_s) begin
            pending_r   <= pending_r & ~clear_mask_s;
            remaining_r <= remaining_r - CNTW'(1);
            none_r      <= 1'b0;
        end else begin
            none_r      <= 1'b0;
        end
    end

    assign out_idx   = find_idx_s;
    assign out_valid = scan_s && find_found_s;
    assign out_last  = last_s;
    assign busy      = scan_s;
    assign none      = none_r;
    assign remaining = remaining_r;

endmodule : priority_scanner

// File: doc/priority_scanner.md
PRIORITY_SCANNER -- requirements
Module: priority_scanner

Interface
REQ-001 Parameter WIDTH, default 16: request vector width; SHALL be >= 2.
REQ-002 Parameter IDXW, default $clog2(WIDTH): index width; derived, not overridden.
REQ-003 Parameter CNTW, default $clog2(WIDTH+1): remaining-count width; derived.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_vec  input  WIDTH  request vector, sampled only on an accepted load.
REQ-007 load  input  1  capture in_vec and mode; accepted only when busy=0.
REQ-008 mode  input  1  0 = highest index first, 1 = lowest index first; sampled with load.
REQ-009 flush  input  1  abort the scan and discard pending bits.
REQ-010 out_idx  output  IDXW  index of the current selected set bit.
REQ-011 out_valid  output  1  out_idx valid.
REQ-012 out_ready  input  1  consumer accepts out_idx when high with out_valid.
REQ-013 out_last  output  1  current index is the final pending bit.
REQ-014 none  output  1  one-cycle pulse: an accepted load captured an all-zero vector.
REQ-015 busy  output  1  scan in progress; loads ignored.
REQ-016 remaining  output  CNTW  popcount of the pending register.

Function
REQ-017 FSM states: IDLE and SCAN.
- Encoding: state enum in the shared package.
REQ-018 IDLE, load=1, in_vec!=0:
- Next edge: pending<=in_vec, dir<=mode, state<=SCAN.
REQ-019 IDLE, load=1, in_vec==0:
- Stay in IDLE.
- none=1 for exactly the following cycle; out_valid stays 0.
REQ-020 busy=1 and out_valid=1 exactly while in SCAN.
- First out_valid: the cycle after the accepting load; latency 1.
REQ-021 out_idx is the highest set bit of pending when dir=0, the lowest when dir=1.
- Derived from registers only; no combinational path from any input.
REQ-022 Accepted transfer (out_valid & out_ready): clear the out_idx bit in pending on that edge.
- Next set bit is presented the following cycle; sustained rate one index per cycle.
REQ-023 out_valid=1 with out_ready=0: out_idx, out_last and remaining SHALL hold stable.
REQ-024 out_last = (remaining == 1) while in SCAN; 0 otherwise.
REQ-025 Accepted transfer with out_last=1: state<=IDLE on the same edge; busy=0 the next cycle.
REQ-026 load while busy=1: ignored; no state change; in_vec not sampled.
REQ-027 flush=1: on the next edge, pending<=0 and state<=IDLE, in any state.
- flush wins over a simultaneous transfer or load; none not asserted.
REQ-028 remaining: 0 in IDLE; popcount(pending) in SCAN.
- Decrements by exactly 1 per accepted transfer.
REQ-029 All-ones vector: exactly WIDTH transfers.
- Indices strictly descending (dir=0) or ascending (dir=1), no repeats, no gaps.
REQ-030 Single set bit: one transfer, with out_last=1 on the first valid cycle.

Reset
REQ-031 rst_n=0 asynchronously forces:
- state=IDLE, pending=0, dir=0.
- out_valid=0, out_idx=0, out_last=0, none=0, busy=0, remaining=0.
REQ-032 Reset mid-scan discards pending bits; no transfer completes after reset deassertion without a new load.
REQ-033 First load is accepted on the first rising edge after rst_n deasserts.

Structure
REQ-034 Package priority_scanner_pkg holds:
- state enum (IDLE, SCAN);
- direction constants DIR_HIGH=0, DIR_LOW=1.
REQ-035 Combinational sub-module pri_find.
- Parameter WIDTH; inputs vec, dir; outputs idx, found.
- Instantiated once on pending; all sequential logic stays in priority_scanner.

Verification
REQ-036 Bench SHALL use WIDTH=16 and cover the following scenarios.
- Reset: rst_n low mid-scan -> all outputs 0 immediately; busy=0 after release.
- Load 0x8421, mode=0, out_ready=1 -> idx 15,10,5,0 on consecutive cycles; out_last only with 0; remaining 4,3,2,1.
- Load 0x8421, mode=1, out_ready toggling 1/0 -> idx 0,5,10,15; out_idx stable during every ready-low cycle.
- Load 0x0000 -> none high one cycle; out_valid and busy stay 0.
- Load 0xFFFF, second load 0x0001 during scan, flush after 3 transfers -> idx 15,14,13; second load ignored; busy=0 the cycle after flush; remaining=0.
- Load 0x0040, mode=0 -> single transfer idx 6 with out_last=1; busy=0 the next cycle.
